pri_arbiter: RTL and testbench

PRI_ARBITER -- requirements
Module: pri_arbiter

---
 rtl/pri_arbiter_if.sv | 13 +
 rtl/pri_arbiter.sv | 50 +++++
 tb/tb_pri_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/pri_arbiter_if.sv
// pri_arbiter_if: request/grant bundle between requesters and the priority arbiter
interface pri_arbiter_if #(
  parameter int N = 8,
  parameter int W = $clog2(N)
);
  logic [N-1:0] in;
  logic         ready;
  logic         valid;
  logic [W-1:0] out;
  logic [N-1:0] grant_oh;
  modport master(output in, ready, input valid, out, grant_oh);
  modport slave(input in, ready, output valid, out, grant_oh);
endinterface

// File: rtl/pri_arbiter.sv
// pri_arbiter: registered fixed or round-robin priority arbiter with ready/valid hold
module pri_arbiter #(
  parameter int N       = 8,
  parameter int W       = $clog2(N),
  parameter int RR_MODE = 0
) (
  input logic           clk,
  input logic           rst,
  pri_arbiter_if.slave  bus
);
  logic [W-1:0] ptr;
  logic [W-1:0] eff_ptr;
  logic [W-1:0] start;
  logic [W-1:0] sel;
  logic [W-1:0] idx;
  logic         load;
  int           j;
  assign load    = !bus.valid || bus.ready;
  assign eff_ptr = (bus.valid && bus.ready) ? (bus.out == '0 ? W'(N-1) : bus.out - 1'b1) : ptr;
  // Search downward from start with wrap at N; the last hit in the loop is the nearest to start.
  // Fixed priority is the same search anchored at N-1.
  always_comb begin
    start = RR_MODE != 0 ? eff_ptr : W'(N-1);
    sel   = '0;
    idx   = '0;
    j     = 0;
    for (int k = N-1; k >= 0; k--) begin
      j   = int'(start) - k;
      j   = j < 0 ? j + N : j;
      idx = W'(j);
      if (bus.in[idx]) sel = idx;
    end
  end
  // Output registers update only on load edges; the pointer tracks eff_ptr every edge in RR mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.valid    <= 1'b0;
      bus.out      <= '0;
      bus.grant_oh <= '0;
      ptr          <= W'(N-1);
    end else begin
      if (RR_MODE != 0) ptr <= eff_ptr;
      if (load) begin
        bus.valid    <= |bus.in;
        bus.out      <= sel;
        bus.grant_oh <= |bus.in ? N'(1) << sel : '0;
      end
    end
  end
endmodule

// File: tb/tb_pri_arbiter.sv
// tb_pri_arbiter: fixed and round-robin arbiters checked against a rotate-and-find-top model
module tb_pri_arbiter;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic rdy = 1'b0;
  int pass_cnt = 0;
  int chk_cnt = 0;
  int mv[2];
  int mo[2];
  int mp[2];
  always #5 clk = ~clk;
  pri_arbiter_if #(.N(N)) bf();
  pri_arbiter_if #(.N(N)) br();
  assign bf.in    = req;
  assign bf.ready = rdy;
  assign br.in    = req;
  assign br.ready = rdy;
  pri_arbiter #(.N(N), .RR_MODE(0)) dut_f (.clk(clk), .rst(rst), .bus(bf));
  pri_arbiter #(.N(N), .RR_MODE(1)) dut_r (.clk(clk), .rst(rst), .bus(br));
  task automatic chk(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask
  function automatic int top_bit(input int v);
    return $clog2(v + 1) - 1;
  endfunction
  // rotate so that channel p lands on the top bit, take the highest set bit, rotate back
  function automatic int pick(input int r, input int p);
    int rot;
    rot = ((r << (N - 1 - p)) | (r >> (p + 1))) & ((1 << N) - 1);
    return (top_bit(rot) - (N - 1 - p) + N) % N;
  endfunction
  task automatic cyc(input logic [N-1:0] r, input logic rd, input logic rs);
    int ep;
    req = r;
    rdy = rd;
    rst = rs;
    for (int m = 0; m < 2; m++) begin
      if (rs) begin
        mv[m] = 0;
        mo[m] = 0;
        mp[m] = N - 1;
      end else begin
        ep = (mv[m] != 0 && rd) ? (mo[m] == 0 ? N - 1 : mo[m] - 1) : mp[m];
        if (m == 1) mp[m] = ep;
        if (mv[m] == 0 || rd) begin
          mv[m] = r != 0;
          mo[m] = r != 0 ? pick(int'(r), m == 1 ? ep : N - 1) : 0;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("f_valid", int'(bf.valid), mv[0]);
    chk("f_out", int'(bf.out), mo[0]);
    chk("f_grant", int'(bf.grant_oh), mv[0] != 0 ? 1 << mo[0] : 0);
    chk("r_valid", int'(br.valid), mv[1]);
    chk("r_out", int'(br.out), mo[1]);
    chk("r_grant", int'(br.grant_oh), mv[1] != 0 ? 1 << mo[1] : 0);
  endtask
  initial begin
    int rr_seq[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    int alt_seq[6] = '{7, 0, 7, 7, 7, 0};
    logic alt_rdy[6] = '{1, 1, 1, 0, 0, 1};
    cyc('0, 1'b0, 1'b1);
    cyc('0, 1'b1, 1'b1);
    chk("reset_valid", int'(bf.valid), 0);
    cyc(8'h81, 1'b1, 1'b0);
    chk("fix_hi_out", int'(bf.out), 7);
    chk("fix_hi_grant", int'(bf.grant_oh), 8'h80);
    cyc(8'h17, 1'b1, 1'b0);
    chk("fix_mid_out", int'(bf.out), 4);
    chk("fix_mid_grant", int'(bf.grant_oh), 8'h10);
    cyc('0, 1'b1, 1'b0);
    chk("fix_idle_valid", int'(bf.valid), 0);
    cyc(8'h54, 1'b0, 1'b0);
    chk("bp_first", int'(bf.out), 6);
    repeat (3) begin
      cyc(8'h01, 1'b0, 1'b0);
      chk("bp_hold", int'(bf.out), 6);
    end
    cyc(8'h01, 1'b1, 1'b0);
    chk("bp_release", int'(bf.out), 0);
    cyc('0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      cyc(8'hFF, 1'b1, 1'b0);
      chk("rr_all", int'(br.out), rr_seq[i]);
    end
    cyc('0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(8'h81, alt_rdy[i], 1'b0);
      chk("rr_alt", int'(br.out), alt_seq[i]);
    end
    cyc('0, 1'b0, 1'b1);
    cyc(8'hFF, 1'b1, 1'b0);
    cyc(8'hFF, 1'b1, 1'b0);
    chk("rr_pre_rst", int'(br.out), 6);
    cyc(8'hFF, 1'b0, 1'b1);
    chk("rr_rst_valid", int'(br.valid), 0);
    chk("rr_rst_out", int'(br.out), 0);
    cyc(8'hFF, 1'b1, 1'b0);
    chk("rr_post_rst", int'(br.out), 7);
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r;
      r = i % 3 == 0 ? N'($urandom & $urandom) : N'($urandom);
      cyc(r, $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
